// File: rtl/miscv_dbg_pkg.sv
// Shared debug/loader types and default sizes used by prog_loader, proc and ram.
package miscv_dbg_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned ADDR_W_DEF = 10;

  typedef enum logic [1:0] {
    OP_HALT = 2'd0,
    OP_LOAD = 2'd1,
    OP_DUMP = 2'd2,
    OP_RUN  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StDumpRd,
    StDumpOut,
    StRun
  } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// Stream-driven program loader / memory dumper; holds the core in reset until a RUN command.
module prog_loader
  import miscv_dbg_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rstL,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_data,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              core_rstL,
  output logic              busy,
  output logic [LEN_W-1:0]  xfer_cnt,
  output logic              wrap_err
);

  localparam int unsigned SumW = LEN_W + 1;

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [LEN_W-1:0]  xfer_q, xfer_d;
  logic              wrap_q, wrap_d;
  logic [XLEN-1:0]   out_data_q, out_data_d;
  // High only in the first DUMP_OUT cycle, when mem_rdata carries the fresh word.
  logic              fresh_q, fresh_d;

  op_e               op;
  logic [SumW-1:0]   end_addr;
  logic              wrap_hit;
  logic              last_word;

  assign op        = op_e'(cmd_op);
  assign end_addr  = SumW'(cmd_addr) + SumW'(cmd_len);
  assign wrap_hit  = end_addr > (SumW'(1) << ADDR_W);
  assign last_word = (rem_q == LEN_W'(1));

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    xfer_d     = xfer_q;
    wrap_d     = wrap_q;
    out_data_d = out_data_q;
    fresh_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          ptr_d  = cmd_addr;
          rem_d  = cmd_len;
          xfer_d = '0;
          wrap_d = 1'b0;
          unique case (op)
            OP_LOAD: begin
              wrap_d = wrap_hit;
              if (cmd_len != '0) state_d = StLoad;
            end
            OP_DUMP: begin
              wrap_d = wrap_hit;
              if (cmd_len != '0) state_d = StDumpRd;
            end
            OP_RUN:  state_d = StRun;
            default: ;
          endcase
        end
      end
      StLoad: begin
        if (in_valid) begin
          ptr_d  = ptr_q + ADDR_W'(1);
          rem_d  = rem_q - LEN_W'(1);
          xfer_d = xfer_q + LEN_W'(1);
          if (last_word) state_d = StIdle;
        end
      end
      StDumpRd: begin
        state_d = StDumpOut;
        fresh_d = 1'b1;
      end
      StDumpOut: begin
        if (fresh_q) out_data_d = mem_rdata;
        if (out_ready) begin
          ptr_d   = ptr_q + ADDR_W'(1);
          rem_d   = rem_q - LEN_W'(1);
          xfer_d  = xfer_q + LEN_W'(1);
          state_d = last_word ? StIdle : StDumpRd;
        end
      end
      StRun: begin
        // Only HALT is honoured while the core owns the RAM.
        if (cmd_valid && op == OP_HALT) begin
          state_d = StIdle;
          xfer_d  = '0;
          wrap_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstL) begin
    if (!rstL) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rem_q      <= '0;
      xfer_q     <= '0;
      wrap_q     <= 1'b0;
      out_data_q <= '0;
      fresh_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      xfer_q     <= xfer_d;
      wrap_q     <= wrap_d;
      out_data_q <= out_data_d;
      fresh_q    <= fresh_d;
    end
  end

  assign cmd_ready = (state_q == StIdle) || (state_q == StRun);
  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDumpOut);
  assign out_data  = fresh_q ? mem_rdata : out_data_q;
  assign mem_we    = (state_q == StLoad) && in_valid;
  assign mem_re    = (state_q == StDumpRd);
  assign mem_addr  = ptr_q;
  assign mem_wdata = in_data;
  assign core_rstL = (state_q == StRun);
  assign busy      = (state_q == StLoad) || (state_q == StDumpRd) || (state_q == StDumpOut);
  assign xfer_cnt  = xfer_q;
  assign wrap_err  = wrap_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a behavioural sync-read RAM on the memory port.
module tb_prog_loader;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned LEN_W  = ADDR_W + 1;

  logic              clk = 1'b0;
  logic              rstL;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_data;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_data;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;
  logic              core_rstL;
  logic              busy;
  logic [LEN_W-1:0]  xfer_cnt;
  logic              wrap_err;

  logic [XLEN-1:0] ram [1024];
  int n_checks = 0;
  int n_pass   = 0;
  int we_cnt   = 0;
  int re_cnt   = 0;
  int both_cnt = 0;
  int we_base;
  int re_base;
  logic [XLEN-1:0] prog [4];

  prog_loader #(.XLEN(XLEN), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rstL      (rstL),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .core_rstL (core_rstL),
    .busy      (busy),
    .xfer_cnt  (xfer_cnt),
    .wrap_err  (wrap_err)
  );

  always #5 clk = ~clk;

  // Read data is only meaningful the cycle after mem_re; garbage otherwise.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
    else        mem_rdata <= 32'hDEADBEEF;
    if (mem_we) we_cnt++;
    if (mem_re) re_cnt++;
    if (mem_we && mem_re) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [ADDR_W-1:0] a,
                          input logic [LEN_W-1:0] l);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = l;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " core_rstL"}, 32'(core_rstL), 32'd0);
    chk({tag, " in_ready"},  32'(in_ready),  32'd0);
    chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " mem_we"},    32'(mem_we),    32'd0);
    chk({tag, " mem_re"},    32'(mem_re),    32'd0);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " wrap_err"},  32'(wrap_err),  32'd0);
    chk({tag, " xfer_cnt"},  32'(xfer_cnt),  32'd0);
    chk({tag, " out_data"},  out_data,       32'd0);
  endtask

  initial begin
    prog[0] = 32'h00500093;
    prog[1] = 32'h00A00113;
    prog[2] = 32'h002081B3;
    prog[3] = 32'h0000006F;
    rstL = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Reset
    #2 rstL = 1'b0;
    #1 chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); #1 rstL = 1'b1;

    // LOAD addr 0, len 4, in_valid held high
    we_base = we_cnt;
    in_valid = 1'b1;
    send_cmd(2'd1, 10'h000, 11'd4);
    chk("load wrap_err", 32'(wrap_err), 32'd0);
    for (int k = 0; k < 4; k++) begin
      in_data = prog[k];
      #1;
      chk("load busy",      32'(busy),      32'd1);
      chk("load in_ready",  32'(in_ready),  32'd1);
      chk("load mem_we",    32'(mem_we),    32'd1);
      chk("load mem_addr",  32'(mem_addr),  32'(k));
      chk("load mem_wdata", mem_wdata,      prog[k]);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("load done busy",     32'(busy),     32'd0);
    chk("load done in_ready", 32'(in_ready), 32'd0);
    chk("load xfer_cnt",      32'(xfer_cnt), 32'd4);
    chk("load we pulses",     32'(we_cnt - we_base), 32'd4);
    for (int k = 0; k < 4; k++) chk("load ram", ram[k], prog[k]);

    // DUMP addr 0, len 4, out_ready toggling with one stall cycle per word
    re_base = re_cnt;
    send_cmd(2'd2, 10'h000, 11'd4);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("dump mem_re",    32'(mem_re),    32'd1);
      chk("dump mem_addr",  32'(mem_addr),  32'(k));
      chk("dump rd out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("dump out_valid", 32'(out_valid), 32'd1);
      chk("dump out_data",  out_data,       prog[k]);
      chk("dump out mem_re", 32'(mem_re),   32'd0);
      @(posedge clk); #1;
      chk("dump stall out_valid", 32'(out_valid), 32'd1);
      chk("dump stall out_data",  out_data,       prog[k]);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    chk("dump done busy",  32'(busy),     32'd0);
    chk("dump xfer_cnt",   32'(xfer_cnt), 32'd4);
    chk("dump re pulses",  32'(re_cnt - re_base), 32'd4);

    // LOAD across the top of memory
    we_base = we_cnt;
    in_valid = 1'b1;
    send_cmd(2'd1, 10'h3FE, 11'd4);
    chk("wrap wrap_err", 32'(wrap_err), 32'd1);
    for (int k = 0; k < 4; k++) begin
      in_data = 32'h1000_0000 + 32'(k);
      #1;
      chk("wrap mem_addr", 32'(mem_addr), (32'h3FE + 32'(k)) & 32'h3FF);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("wrap xfer_cnt",   32'(xfer_cnt), 32'd4);
    chk("wrap err held",   32'(wrap_err), 32'd1);
    chk("wrap ram 3FE",    ram[10'h3FE], 32'h1000_0000);
    chk("wrap ram 3FF",    ram[10'h3FF], 32'h1000_0001);
    chk("wrap ram 000",    ram[10'h000], 32'h1000_0002);
    chk("wrap ram 001",    ram[10'h001], 32'h1000_0003);
    chk("wrap we pulses",  32'(we_cnt - we_base), 32'd4);

    // Zero-length LOAD then DUMP
    we_base = we_cnt;
    re_base = re_cnt;
    in_valid = 1'b1;
    send_cmd(2'd1, 10'h000, 11'd0);
    chk("len0 load wrap cleared", 32'(wrap_err),  32'd0);
    chk("len0 load xfer_cnt",     32'(xfer_cnt),  32'd0);
    chk("len0 load busy",         32'(busy),      32'd0);
    chk("len0 load cmd_ready",    32'(cmd_ready), 32'd1);
    in_valid = 1'b0;
    send_cmd(2'd2, 10'h000, 11'd0);
    chk("len0 dump busy",         32'(busy),      32'd0);
    chk("len0 dump cmd_ready",    32'(cmd_ready), 32'd1);
    chk("len0 dump xfer_cnt",     32'(xfer_cnt),  32'd0);
    @(posedge clk); #1;
    chk("len0 we pulses", 32'(we_cnt - we_base), 32'd0);
    chk("len0 re pulses", 32'(re_cnt - re_base), 32'd0);

    // RUN, LOAD ignored while running, then HALT
    send_cmd(2'd3, 10'h000, 11'd0);
    chk("run core_rstL", 32'(core_rstL), 32'd1);
    chk("run cmd_ready", 32'(cmd_ready), 32'd1);
    we_base = we_cnt;
    in_valid = 1'b1;
    in_data  = 32'hFFFF_FFFF;
    send_cmd(2'd1, 10'h000, 11'd2);
    for (int k = 0; k < 3; k++) begin
      chk("run mem_we",    32'(mem_we),    32'd0);
      chk("run in_ready",  32'(in_ready),  32'd0);
      chk("run busy",      32'(busy),      32'd0);
      chk("run cmd_ready", 32'(cmd_ready), 32'd1);
      chk("run held",      32'(core_rstL), 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("run we pulses", 32'(we_cnt - we_base), 32'd0);
    send_cmd(2'd0, 10'h000, 11'd0);
    chk("halt core_rstL", 32'(core_rstL), 32'd0);
    chk("halt cmd_ready", 32'(cmd_ready), 32'd1);

    // Async reset after two of four LOAD words
    we_base = we_cnt;
    in_valid = 1'b1;
    send_cmd(2'd1, 10'h000, 11'd4);
    for (int k = 0; k < 2; k++) begin
      in_data = 32'hCAFE_0000 + 32'(k);
      @(posedge clk); #1;
    end
    in_data = 32'hCAFE_0002;
    rstL = 1'b0;
    #1 chk_reset_outputs("abort");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("abort we pulses", 32'(we_cnt - we_base), 32'd2);
    chk("abort ram 0", ram[0], 32'hCAFE_0000);
    chk("abort ram 1", ram[1], 32'hCAFE_0001);
    chk("abort ram 2", ram[2], prog[2]);
    chk("abort ram 3", ram[3], prog[3]);
    rstL = 1'b1;
    @(posedge clk); #1;
    chk("mem strobes never overlap", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Synthesizable program-load and memory-dump engine that sits between a host word stream and the proc instruction/data RAM port.
- Holds the core in reset while it loads N words at any base address, and can read back N words as a stream.
- Releases the core on a RUN command.
- Replaces the simulation-only hex preload and per-cycle memory printing with a parametrised, stream-driven block usable on silicon and in benches.

Parameters:
XLEN, 32, data word width in bits
ADDR_W, 10, RAM word-address width (depth = 2**ADDR_W words)
LEN_W, ADDR_W+1, width of command length field (max length = 2**ADDR_W)

Ports:
clk  input  1  system clock
rstL  input  1  asynchronous active-low reset
cmd_valid  input  1  command handshake valid
cmd_ready  output  1  command handshake ready
cmd_op  input  2  0=HALT 1=LOAD 2=DUMP 3=RUN
cmd_addr  input  ADDR_W  start word address
cmd_len  input  LEN_W  word count
in_valid  input  1  load-data valid
in_ready  output  1  load-data ready
in_data  input  XLEN  load word
out_valid  output  1  dump-data valid
out_ready  input  1  dump-data ready
out_data  output  XLEN  dump word
mem_we  output  1  RAM write enable
mem_re  output  1  RAM read enable (read data on mem_rdata the next cycle)
mem_addr  output  ADDR_W  RAM word address
mem_wdata  output  XLEN  RAM write data
mem_rdata  input  XLEN  RAM read data
core_rstL  output  1  active-low reset to proc; 0 unless in RUN
busy  output  1  LOAD or DUMP in progress
xfer_cnt  output  LEN_W  words transferred by current/last command
wrap_err  output  1  sticky: current/last command crossed the top of memory

Behaviour:
- Reset (async, rstL=0):
  - state=IDLE, core_rstL=0, cmd_ready=1.
  - in_ready, out_valid, mem_we, mem_re, busy and wrap_err = 0; xfer_cnt=0; out_data=0.
- States: IDLE, LOAD, DUMP_RD, DUMP_OUT, RUN.
- cmd_ready=1 only in IDLE and RUN.
  - In RUN, only HALT has effect; other ops are accepted and ignored.
  - In IDLE, HALT is a no-op.
- Command accept (cmd_valid&cmd_ready):
  - latch ptr=cmd_addr, remaining=cmd_len.
  - clear xfer_cnt and wrap_err.
  - set wrap_err if cmd_addr+cmd_len > 2**ADDR_W. Addresses wrap modulo 2**ADDR_W; the transfer still completes.
- LOAD, len=0: return to IDLE next cycle; no memory access.
- LOAD, len>0: go to LOAD, in_ready=1.
  - Each in handshake drives mem_we=1, mem_addr=ptr and mem_wdata=in_data combinationally in that same cycle.
  - Then ptr++, remaining--, xfer_cnt++.
  - After the last word, go to IDLE (in_ready=0 in the following cycle).
- DUMP, len=0: same as LOAD len=0.
- DUMP, len>0:
  - DUMP_RD: assert mem_re=1, mem_addr=ptr for exactly one cycle, then go to DUMP_OUT.
  - DUMP_OUT: capture mem_rdata into out_data on entry; out_valid=1.
  - out_data must be stable while out_valid&!out_ready.
  - On handshake: ptr++, remaining--, xfer_cnt++. Go to DUMP_RD if remaining>0, else IDLE.
  - Throughput is 1 word per 2 cycles minimum; back-pressure may stall indefinitely.
- RUN:
  - core_rstL=1, registered, deasserting the cycle after the RUN accept.
  - mem_we=mem_re=0; the external mux gives the RAM to the core whenever core_rstL=1.
  - HALT accept: core_rstL=0 next cycle, state=IDLE.
- busy=1 exactly in LOAD, DUMP_RD, DUMP_OUT.
- Never assert mem_we and mem_re together. Both are 0 in IDLE and RUN.
- xfer_cnt saturates at cmd_len by construction; it holds its value in IDLE until the next accept.
- A simultaneous in_valid during DUMP, or out_ready during LOAD, is ignored.
- Async reset mid-LOAD/DUMP:
  - abort immediately; no further mem strobes.
  - words already written remain in RAM.
  - core_rstL=0.

Decomposition:
- Package miscv_dbg_pkg:
  - op enum (OP_HALT, OP_LOAD, OP_DUMP, OP_RUN).
  - loader state enum.
  - default XLEN/ADDR_W constants shared with proc and ram.
- No sub-module is warranted: a single FSM plus ptr, remaining and xfer_cnt counters.

Test Plan:
- Reset, then LOAD addr=0 len=4 with words 00500093, 00A00113, 002081B3, 0000006F, in_valid held high -> four consecutive mem_we cycles at addresses 0..3; xfer_cnt=4; busy falls; RAM holds those words.
- DUMP addr=0 len=4 with out_ready toggling 1/0 -> out_data sequence 00500093, 00A00113, 002081B3, 0000006F; each word held stable while stalled; exactly 4 mem_re pulses.
- LOAD addr=0x3FE len=4 (ADDR_W=10) -> writes to 0x3FE, 0x3FF, 0x000, 0x001; wrap_err=1; next accepted command clears wrap_err.
- LOAD len=0, then DUMP len=0 -> each back in IDLE one cycle after accept; no mem_we/mem_re; xfer_cnt=0.
- RUN, then check proc loads x3=0x0000000F -> core_rstL=1 one cycle after accept; LOAD issued during RUN has no mem strobes; HALT -> core_rstL=0 next cycle; cmd_ready=1 throughout.
- Assert rstL=0 after 2 of 4 LOAD words -> all outputs at reset values asynchronously; RAM words 0..1 written, 2..3 untouched.
